// File: rtl/uart_cmd_rx_pkg.sv
// rtl/uart_cmd_rx_pkg.sv - command byte codes and FSM encodings for uart_cmd_rx
package uart_cmd_rx_pkg;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        ST_CMD,
        ST_ADR,
        ST_DAT,
        ST_BUS
    } cmd_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with synchronizer and framing check
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frm_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             line;

    assign line = sync_q[1];

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rxd};
        prev_d  = line;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                // only a genuine high-to-low transition starts a frame
                if (prev_q && !line) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    vld_d   = line;
                    err_d   = !line;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign byte_o     = shift_q;
    assign byte_vld_o = vld_q;
    assign frm_err_o  = err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART command frames to single Wishbone register accesses
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd,
    output logic       stb_o,
    output logic       we_o,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i,
    output logic [7:0] rd_dat_o,
    output logic       rd_vld_o,
    output logic       err_o,
    output logic       busy_o
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_frm_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rxd       (rxd),
        .byte_o    (rx_byte),
        .byte_vld_o(rx_vld),
        .frm_err_o (rx_frm_err)
    );

    cmd_state_e       state_q, state_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [7:0]       adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;
    logic [7:0]       rd_dat_q, rd_dat_d;
    logic             rd_vld_q, rd_vld_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rd_dat_d = rd_dat_q;
        rd_vld_d = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_CMD: begin
                if (rx_frm_err) begin
                    err_d = 1'b1;
                end else if (rx_vld && (rx_byte == CMD_WR || rx_byte == CMD_RD)) begin
                    state_d = ST_ADR;
                    we_d    = (rx_byte == CMD_WR);
                    busy_d  = 1'b1;
                end
            end
            ST_ADR: begin
                if (rx_frm_err) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_CMD;
                end else if (rx_vld) begin
                    adr_d = rx_byte;
                    if (we_q) begin
                        state_d = ST_DAT;
                    end else begin
                        state_d = ST_BUS;
                        stb_d   = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            ST_DAT: begin
                if (rx_frm_err) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_CMD;
                end else if (rx_vld) begin
                    dat_d   = rx_byte;
                    state_d = ST_BUS;
                    stb_d   = 1'b1;
                    tmo_d   = '0;
                end
            end
            ST_BUS: begin
                // bytes arriving mid-cycle are dropped; the bus cycle runs on
                err_d = rx_vld || rx_frm_err;
                tmo_d = tmo_q + 1'b1;
                if (ack_i) begin
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_CMD;
                    if (!we_q) begin
                        rd_dat_d = dat_i;
                        rd_vld_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_CMD;
                end
            end
            default: state_d = ST_CMD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_CMD;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 8'h00;
            dat_q    <= 8'h00;
            rd_dat_q <= 8'h00;
            rd_vld_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rd_dat_q <= rd_dat_d;
            rd_vld_q <= rd_vld_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    assign stb_o    = stb_q;
    assign we_o     = we_q;
    assign adr_o    = adr_q;
    assign dat_o    = dat_q;
    assign rd_dat_o = rd_dat_q;
    assign rd_vld_o = rd_vld_q;
    assign err_o    = err_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;

    localparam int CPB = 16;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       rxd = 1'b1;
    logic       ack_i = 1'b0;
    logic [7:0] dat_i = 8'h00;
    logic       stb_o, we_o, rd_vld_o, err_o, busy_o;
    logic [7:0] adr_o, dat_o, rd_dat_o;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .rxd     (rxd),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i),
        .rd_dat_o(rd_dat_o),
        .rd_vld_o(rd_vld_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // slave model / monitor state
    int         ack_at = 0;
    logic [7:0] slave_dat = 8'h00;
    int         stb_cnt = 0;
    int         n_bus = 0, n_rdv = 0, n_err = 0, last_w = 0;
    logic       last_we = 1'b0;
    logic [7:0] last_adr = 8'h00, last_dat = 8'h00, last_rd = 8'h00;
    int         b_bus, b_rdv, b_err;

    always @(negedge clk) begin
        if (rd_vld_o) begin
            n_rdv++;
            last_rd = rd_dat_o;
        end
        if (err_o) n_err++;
        dat_i = slave_dat;
        if (stb_o) begin
            stb_cnt++;
            last_we  = we_o;
            last_adr = adr_o;
            last_dat = dat_o;
            if (ack_at != 0 && stb_cnt >= ack_at) ack_i = 1'b1;
        end else begin
            if (stb_cnt > 0) begin
                n_bus++;
                last_w = stb_cnt;
            end
            stb_cnt = 0;
            ack_i   = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_bus = n_bus;
        b_rdv = n_rdv;
        b_err = n_err;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < TMO + 400; i++) begin
            if (!busy_o && !stb_o) break;
            @(negedge clk);
        end
        check(tag, {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    logic [7:0] model_dat;
    logic [7:0] junk, r_adr, r_dat, r_rd;
    logic       r_we;
    int         r_ack, r_junk;

    initial begin
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {7'd0, stb_o, we_o, adr_o, dat_o, rd_dat_o, rd_vld_o, err_o, busy_o}, 32'd0);
        rst_i = 1'b1;
        repeat (4) @(negedge clk);

        // write with ack asserted on third strobe cycle
        snap();
        ack_at = 3;
        send_byte(8'h57, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'hA5, 1'b1);
        wait_idle("wr_busy");
        check("wr_count", n_bus - b_bus, 1);
        check("wr_we", {31'd0, last_we}, 1);
        check("wr_adr", last_adr, 8'h31);
        check("wr_dat", last_dat, 8'hA5);
        check("wr_width", last_w, 3);
        check("wr_err", n_err - b_err, 0);
        check("wr_rdv", n_rdv - b_rdv, 0);
        check("wr_hold_adr", adr_o, 8'h31);
        model_dat = 8'hA5;

        // read
        snap();
        ack_at = 2;
        slave_dat = 8'h5C;
        send_byte(8'h52, 1'b1);
        send_byte(8'h42, 1'b1);
        wait_idle("rd_busy");
        check("rd_count", n_bus - b_bus, 1);
        check("rd_we", {31'd0, last_we}, 0);
        check("rd_adr", last_adr, 8'h42);
        check("rd_rdv", n_rdv - b_rdv, 1);
        check("rd_data", last_rd, 8'h5C);
        check("rd_dat_o", rd_dat_o, 8'h5C);
        check("rd_err", n_err - b_err, 0);

        // read timeout
        snap();
        ack_at = 0;
        slave_dat = 8'hEE;
        send_byte(8'h52, 1'b1);
        send_byte(8'hF0, 1'b1);
        wait_idle("to_busy");
        check("to_width", last_w, TMO);
        check("to_adr", last_adr, 8'hF0);
        check("to_err", n_err - b_err, 1);
        check("to_rdv", n_rdv - b_rdv, 0);
        check("to_rd_hold", rd_dat_o, 8'h5C);

        // framing error aborts pending write, then read proceeds
        snap();
        ack_at = 1;
        slave_dat = 8'h77;
        send_byte(8'h57, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_idle("fe_busy");
        check("fe_err", n_err - b_err, 1);
        check("fe_count", n_bus - b_bus, 1);
        check("fe_we", {31'd0, last_we}, 0);
        check("fe_adr", last_adr, 8'h10);
        check("fe_rd", last_rd, 8'h77);

        // glitch and stray 0x00 ignored
        snap();
        ack_at = 2;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_byte(8'h00, 1'b1);
        check("gl_idle", {31'd0, busy_o}, 0);
        send_byte(8'h52, 1'b1);
        send_byte(8'h20, 1'b1);
        wait_idle("gl_busy");
        check("gl_err", n_err - b_err, 0);
        check("gl_count", n_bus - b_bus, 1);
        check("gl_adr", last_adr, 8'h20);

        // overrun during a long read: byte dropped, err once, read completes
        snap();
        ack_at = 190;
        slave_dat = 8'h3C;
        send_byte(8'h52, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h57, 1'b1);
        wait_idle("ov_busy");
        check("ov_err", n_err - b_err, 1);
        check("ov_rdv", n_rdv - b_rdv, 1);
        check("ov_rd", last_rd, 8'h3C);
        check("ov_width", last_w, 190);
        snap();
        ack_at = 2;
        slave_dat = 8'h9D;
        send_byte(8'h52, 1'b1);
        send_byte(8'h33, 1'b1);
        wait_idle("ov2_busy");
        check("ov2_we", {31'd0, last_we}, 0);
        check("ov2_adr", last_adr, 8'h33);
        check("ov2_rd", last_rd, 8'h9D);
        check("ov2_err", n_err - b_err, 0);

        // randomized commands with junk prefix bytes
        for (int k = 0; k < 8; k++) begin
            r_junk = $urandom_range(0, 2);
            r_we   = 1'($urandom_range(0, 1));
            r_adr  = 8'($urandom);
            r_dat  = 8'($urandom);
            r_rd   = 8'($urandom);
            r_ack  = $urandom_range(1, 12);
            snap();
            ack_at = r_ack;
            slave_dat = r_rd;
            for (int j = 0; j < r_junk; j++) begin
                junk = 8'($urandom);
                if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
                send_byte(junk, 1'b1);
            end
            send_byte(r_we ? 8'h57 : 8'h52, 1'b1);
            send_byte(r_adr, 1'b1);
            if (r_we) begin
                send_byte(r_dat, 1'b1);
                model_dat = r_dat;
            end
            wait_idle("rnd_busy");
            check("rnd_count", n_bus - b_bus, 1);
            check("rnd_we", {31'd0, last_we}, {31'd0, r_we});
            check("rnd_adr", last_adr, r_adr);
            check("rnd_dat", last_dat, model_dat);
            check("rnd_width", last_w, r_ack);
            check("rnd_rdv", n_rdv - b_rdv, r_we ? 0 : 1);
            if (!r_we) check("rnd_rd", rd_dat_o, r_rd);
            check("rnd_err", n_err - b_err, 0);
        end

        // async reset while strobe is high
        ack_at = 0;
        send_byte(8'h52, 1'b1);
        send_byte(8'h44, 1'b1);
        check("rst_stb_seen", {31'd0, stb_o}, 1);
        @(negedge clk);
        #2 rst_i = 1'b0;
        #1;
        check("rst_async", {7'd0, stb_o, we_o, adr_o, dat_o, rd_dat_o, rd_vld_o, err_o, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        snap();
        ack_at = 1;
        send_byte(8'h57, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_idle("post_busy");
        check("post_count", n_bus - b_bus, 1);
        check("post_we", {31'd0, last_we}, 1);
        check("post_adr", last_adr, 8'h12);
        check("post_dat", last_dat, 8'h34);
        check("post_err", n_err - b_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command receiver that turns byte frames arriving from the LPC microcontroller on TX1 into single Wishbone register accesses on the internal 8-bit slave bus (channel ports, clock generators). It is the receive-side counterpart of the read-FIFO serializer that drives RX1. Read results are presented on a one-byte output for the serializer to send back. It is a second bus master beside the parallel krake bus; arbitration is outside this block.

## Interface
Parameters:
- CLKS_PER_BIT, 434: system clocks per UART bit (50 MHz / 115200); minimum 4.
- ACK_TIMEOUT, 255: maximum clocks stb_o stays high without ack_i.

Ports:
- clk_i  in  1  system clock (GLA domain); all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- rxd  in  1  UART receive line (TX1), idle high, asynchronous to clk_i.
- stb_o  out  1  Wishbone strobe (also serves as cyc).
- we_o  out  1  Wishbone write enable.
- adr_o  out  8  Wishbone address; [7:4] selects the slave, [3:0] the register.
- dat_o  out  8  Wishbone write data.
- dat_i  in  8  Wishbone read data, valid with ack_i.
- ack_i  in  1  Wishbone acknowledge.
- rd_dat_o  out  8  last read result.
- rd_vld_o  out  1  one-cycle pulse: rd_dat_o updated.
- err_o  out  1  one-cycle pulse: framing error, overrun, or bus timeout.
- busy_o  out  1  high from first command byte accepted until the command completes.

## Operation
- Reset: every output is 0; both FSMs idle; rxd synchronizer preset to 1.
- Byte receiver, 8N1, LSB first. rxd passes through a 2-FF synchronizer. Falling edge in IDLE -> START. At CLKS_PER_BIT/2 the line is resampled: still low -> DATA, high -> IDLE (glitch, no error). DATA samples 8 bits, each CLKS_PER_BIT apart. STOP samples once more: high -> byte_valid for 1 cycle; low -> framing error (err_o pulse, byte dropped). Returns to IDLE at the stop-bit midpoint.
- Command FSM, states CMD, ADR, DAT, BUS:
  - CMD: byte 0x57 ('W') -> ADR with we=1; byte 0x52 ('R') -> ADR with we=0; any other byte is ignored silently.
  - ADR: byte -> adr register; write -> DAT; read -> BUS.
  - DAT: byte -> dat register -> BUS.
  - BUS: stb_o=1 with stable we_o/adr_o/dat_o. ack_i=1 -> stb_o=0, and for a read rd_dat_o<=dat_i with a rd_vld_o pulse -> CMD. Timeout -> stb_o=0, err_o pulse, rd_vld_o stays low, rd_dat_o unchanged -> CMD.
- A byte completed while in BUS is an overrun: dropped, err_o pulses, the bus cycle is not disturbed.
- A framing error in ADR or DAT aborts the command: -> CMD, busy_o=0.
- adr_o/dat_o/we_o hold their last values after the cycle; only stb_o qualifies them.

## Timing
- byte_valid follows the stop-bit sample clock by 1 cycle; stb_o rises on the cycle after byte_valid of the final byte (ADR for reads, DAT for writes).
- ack_i is sampled only while stb_o=1. stb_o drops on the clock edge that samples ack_i=1. rd_vld_o and rd_dat_o update on that same edge.
- The timeout counter clears when stb_o rises and increments each stb_o cycle. When the count reaches ACK_TIMEOUT with no ack_i, stb_o drops and err_o pulses on that edge. ack_i on the same edge wins: no error.
- If ack_i and an overrun byte_valid occur in the same cycle, the ack is honored and err_o pulses once.
- Async reset mid-frame or mid-cycle forces stb_o low immediately. The next frame is accepted only after a fresh falling edge on rxd.
- Counter widths: $clog2(CLKS_PER_BIT) bit timer, 3-bit bit index, $clog2(ACK_TIMEOUT+1) timeout.

## Structure
- Shared package/include: CMD_WR=8'h57, CMD_RD=8'h52, receiver and command FSM state encodings.
- One sub-module: uart_rx_byte (synchronizer, bit timer, byte/frame-error outputs). Command FSM and Wishbone logic live in uart_cmd_rx.

## Test plan
- Frames 0x57,0x31,0xA5 with ack_i 2 cycles after stb_o -> one write, adr_o=0x31, dat_o=0xA5, we_o=1, stb_o high for exactly 3 cycles, no err_o.
- Frames 0x52,0x42, slave returns dat_i=0x5C with ack -> we_o=0, one rd_vld_o pulse, rd_dat_o=0x5C.
- Read to adr 0xF0, ack_i never asserted -> stb_o high for exactly ACK_TIMEOUT cycles, then one err_o pulse, no rd_vld_o, busy_o low afterwards.
- 0x57,0x31, then a frame with stop bit low, then 0x52,0x10 -> err_o once, no write issued, read of 0x10 completes.
- Half-bit-wide low glitch, then 0x00 byte, then valid 0x52,0x20 -> glitch and 0x00 ignored, no err_o, read issued.
- Reset asserted while stb_o high -> stb_o low asynchronously, all outputs 0, next full command executes normally.
